// File: rtl/osd_wr_arbiter.sv
// osd_wr_arbiter
//
// This block arbitrates two character-write requesters onto one char RAM write
// port. It can also run an optional engine that fills the whole screen with a
// single character.
//
// Arbitration:
// - A lone valid requester is granted directly.
// - When both requesters are valid, the one not granted most recently wins.
//
// Write timing and drops:
// - An accepted beat appears on wr_* one cycle later.
// - Beats whose address is at or beyond CHAR_RAM_SIZE are consumed but not
//   written. Each one increments a saturating drop counter.
//
// Optional feature (macro OSD_WR_ARBITER_CLEAR_EN):
// - Defining OSD_WR_ARBITER_CLEAR_EN builds the fill engine.
// - A clear_start pulse in IDLE latches clear_char and stalls both requesters.
// - The engine then writes addresses 0..CHAR_RAM_SIZE-1 one per cycle.
// - clear_done is raised on the last write.
// - Without the macro, clear_start/clear_char are ignored and clear_busy and
//   clear_done are tied low.
//
// Ports:
//   clk, reset_n                   single clock, synchronous active-low reset
//   reqN_valid/addr/data/ready     requester N write handshake (N = 0, 1)
//   clear_start, clear_char        fill request pulse and fill character
//   clear_busy, clear_done         fill in progress / pulse on final fill write
//   wr_addr, wr_data, wr_en        char RAM write port (registered)
//   drop_count                     saturating count of out-of-range beats
module osd_wr_arbiter #(
  parameter int COLS          = 40,
  parameter int ROWS          = 30,
  parameter int CHAR_RAM_SIZE = COLS * ROWS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [10:0] req0_addr,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [10:0] req1_addr,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        clear_start,
  input  logic [7:0]  clear_char,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic [7:0]  drop_count
);

  localparam logic [11:0] RAM_SIZE  = 12'(CHAR_RAM_SIZE);
  localparam logic [10:0] LAST_ADDR = 11'(CHAR_RAM_SIZE - 1);

  logic        wr_en_q;
  logic [10:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [7:0]  drop_q;
  logic        last_grant_q;   // 1: req1 was granted most recently

  logic        arb_open;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [10:0] acc_addr;
  logic [7:0]  acc_data;
  logic        acc_in_range;

`ifdef OSD_WR_ARBITER_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t      state_q;
  logic [10:0] fill_q;         // address currently shown on wr_addr during a fill
  logic [10:0] fill_d;
  logic [7:0]  fill_char_q;
  logic        done_q;

  // A clear_start seen in IDLE takes priority over any request in that cycle.
  assign arb_open   = reset_n & (state_q == ST_IDLE) & ~clear_start;
  assign fill_d     = fill_q + 11'd1;
  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = done_q;
`else
  logic unused_clear;

  assign arb_open     = reset_n;
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
  assign unused_clear = ^{clear_start, clear_char};
`endif

  always_comb begin
    grant0       = req0_valid & (~req1_valid | last_grant_q);
    grant1       = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready   = arb_open & grant0;
    req1_ready   = arb_open & grant1;
    accept       = req0_ready | req1_ready;
    acc_addr     = req1_ready ? req1_addr : req0_addr;
    acc_data     = req1_ready ? req1_data : req0_data;
    acc_in_range = ({1'b0, acc_addr} < RAM_SIZE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_q       <= '0;
      last_grant_q <= 1'b1;
`ifdef OSD_WR_ARBITER_CLEAR_EN
      state_q      <= ST_IDLE;
      fill_q       <= '0;
      fill_char_q  <= '0;
      done_q       <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (accept) begin
        last_grant_q <= req1_ready;
        if (acc_in_range) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= acc_addr;
          wr_data_q <= acc_data;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end
`ifdef OSD_WR_ARBITER_CLEAR_EN
      case (state_q)
        ST_IDLE: begin
          if (clear_start) begin
            // The first fill write is registered on the same edge.
            state_q     <= ST_CLEAR;
            fill_q      <= '0;
            fill_char_q <= clear_char;
            wr_en_q     <= 1'b1;
            wr_addr_q   <= '0;
            wr_data_q   <= clear_char;
            done_q      <= (LAST_ADDR == 11'd0);
          end
        end
        ST_CLEAR: begin
          // Terminate on equality so the counter never wraps.
          if (fill_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else begin
            fill_q    <= fill_d;
            wr_en_q   <= 1'b1;
            wr_addr_q <= fill_d;
            wr_data_q <= fill_char_q;
            done_q    <= (fill_d == LAST_ADDR);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_osd_wr_arbiter.sv
module tb_osd_wr_arbiter;

  localparam int SIZE = 1200;
`ifdef OSD_WR_ARBITER_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [10:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        clear_start = 1'b0;
  logic [7:0]  clear_char = '0;
  logic        clear_busy, clear_done;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  osd_wr_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_char(clear_char),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .drop_count(drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the outputs must show in the current cycle.
  int m_last      = 1;   // requester granted most recently
  int m_drop      = 0;
  int m_fill_left = 0;   // fill writes still to be issued
  int m_char      = 0;
  bit m_wr_en = 0, m_busy = 0, m_done = 0;
  int m_addr = 0, m_data = 0;

  // Grants predicted by the model, and DUT outputs observed in the last cycle.
  bit g0, g1;
  bit obs_r0, obs_r1, obs_en, obs_busy, obs_done;
  int obs_addr, obs_data;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one cycle of outputs, then advance the model across the next edge.
  task automatic cycle();
    bit arb_ok;
    int a, d;
    @(negedge clk);
    arb_ok = reset_n && !m_busy && !(CLR_EN && clear_start);
    g0 = arb_ok && req0_valid && (!req1_valid || m_last == 1);
    g1 = arb_ok && req1_valid && (!req0_valid || m_last == 0);
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_en = wr_en;
    obs_busy = clear_busy; obs_done = clear_done;
    obs_addr = wr_addr; obs_data = wr_data;
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("wr_en", wr_en, m_wr_en);
    chk("clear_busy", clear_busy, m_busy);
    chk("clear_done", clear_done, m_done);
    chk("drop_count", drop_count, m_drop);
    if (m_wr_en) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
    end
    if (!reset_n) begin
      m_last = 1; m_drop = 0; m_fill_left = 0;
      m_wr_en = 0; m_busy = 0; m_done = 0; m_addr = 0; m_data = 0;
    end else begin
      if (CLR_EN && clear_start && !m_busy) begin
        m_fill_left = SIZE;
        m_char = clear_char;
      end
      if (m_fill_left > 0) begin
        m_wr_en = 1; m_addr = SIZE - m_fill_left; m_data = m_char;
        m_fill_left--;
        m_busy = 1; m_done = (m_fill_left == 0);
      end else begin
        m_wr_en = 0; m_busy = 0; m_done = 0;
        if (g0 || g1) begin
          a = g1 ? int'(req1_addr) : int'(req0_addr);
          d = g1 ? int'(req1_data) : int'(req0_data);
          m_last = g1 ? 1 : 0;
          if (a < SIZE) begin
            m_wr_en = 1; m_addr = a; m_data = d;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; clear_start = 0;
  endtask

  initial begin
    int grants[4];
    int cnt, writes, dones, done_addr, bad_order;
    bit seen;

    @(posedge clk); #1;
    // Reset with requests pending: readys must stay low.
    reset_n = 0; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) cycle();
    idle_inputs();
    cycle();
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_drop", drop_count, 0);
    chk("reset_busy", clear_busy, 0);
    reset_n = 1;

    // Single write.
    req0_valid = 1; req0_addr = 11'd5; req0_data = 8'h41;
    cycle();
    chk("single_ready0", obs_r0, 1);
    idle_inputs();
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_addr", wr_addr, 5);
    chk("single_wr_data", wr_data, 8'h41);
    cycle();

    // Contention right after reset: 0,1,0,1.
    reset_n = 0; cycle(); reset_n = 1;
    req0_valid = 1; req0_addr = 11'd10; req0_data = 8'hA0;
    req1_valid = 1; req1_addr = 11'd20; req1_data = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      grants[i] = obs_r1 ? 1 : (obs_r0 ? 0 : -1);
      if (i > 0) chk("contend_wr_addr", wr_addr, (i % 2 == 1) ? 20 : 10);
    end
    idle_inputs();
    chk("contend_g0", grants[0], 0);
    chk("contend_g1", grants[1], 1);
    chk("contend_g2", grants[2], 0);
    chk("contend_g3", grants[3], 1);
    cycle();

    // Out-of-range drops and saturation.
    req1_valid = 1; req1_addr = 11'd1200; req1_data = 8'h33;
    cycle();
    chk("oor_ready1", obs_r1, 1);
    chk("oor_wr_en", wr_en, 0);
    chk("oor_drop1", drop_count, 1);
    for (int i = 0; i < 299; i++) begin
      req1_addr = 11'(1200 + (i % 800));
      cycle();
    end
    idle_inputs();
    chk("oor_drop_sat", drop_count, 255);
    cycle();

`ifdef OSD_WR_ARBITER_CLEAR_EN
    // Full fill with a request arriving together with clear_start.
    reset_n = 0; cycle(); reset_n = 1;
    clear_start = 1; clear_char = 8'h20;
    req0_valid = 1; req0_addr = 11'd7; req0_data = 8'h55;
    cycle();
    chk("fill_start_ready0", obs_r0, 0);
    clear_start = 0;
    cnt = 0; writes = 0; dones = 0; done_addr = -1; bad_order = 0; seen = 0;
    for (int i = 0; i < 1400 && !seen; i++) begin
      if (i == 300) clear_start = 1;   // ignored mid-fill
      if (i == 301) clear_start = 0;
      cycle();
      if (obs_r0) seen = 1;
      else cnt++;
      if (obs_busy && obs_en) begin
        if (obs_addr != writes || obs_data != 8'h20) bad_order++;
        writes++;
      end
      if (obs_done) begin dones++; done_addr = obs_addr; end
    end
    req0_valid = 0;
    chk("fill_req0_accepted", seen, 1);
    chk("fill_stall_cycles", cnt, 1200);
    chk("fill_writes", writes, 1200);
    chk("fill_order", bad_order, 0);
    chk("fill_done_count", dones, 1);
    chk("fill_done_addr", done_addr, 1199);
    chk("fill_req_write_addr", wr_addr, 7);
    cycle();

    // Abort mid-fill with reset, then restart from address 0.
    clear_start = 1; clear_char = 8'h2E;
    cycle();
    clear_start = 0;
    seen = 0;
    for (int i = 0; i < 1300 && !seen; i++) begin
      cycle();
      if (obs_busy && obs_addr == 600) seen = 1;
    end
    chk("abort_reached_600", seen, 1);
    reset_n = 0;
    cycle();
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", clear_busy, 0);
    chk("abort_done", clear_done, 0);
    reset_n = 1;
    clear_start = 1; clear_char = 8'h2A;
    cycle();
    clear_start = 0;
    chk("restart_addr", wr_addr, 0);
    chk("restart_data", wr_data, 8'h2A);
    seen = 0;
    for (int i = 0; i < 1300 && !seen; i++) begin
      cycle();
      if (obs_done) seen = 1;
    end
    chk("restart_done", seen, 1);
    cycle();
`else
    // Fill engine absent: clear_start has no effect on arbitration.
    clear_start = 1; clear_char = 8'h20;
    req0_valid = 1; req0_addr = 11'd9; req0_data = 8'h66;
    cycle();
    chk("noclr_ready0", obs_r0, 1);
    chk("noclr_busy", obs_busy, 0);
    idle_inputs();
    chk("noclr_wr_en", wr_en, 1);
    chk("noclr_wr_addr", wr_addr, 9);
    chk("noclr_busy_after", clear_busy, 0);
    cycle();
`endif

    // Randomized traffic; pending requests are held until granted.
    for (int i = 0; i < 3000; i++) begin
      if (!(req0_valid && !g0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = 11'($urandom_range(0, 1300));
        req0_data  = 8'($urandom);
      end
      if (!(req1_valid && !g1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = 11'($urandom_range(0, 1300));
        req1_data  = 8'($urandom);
      end
      reset_n     = ($urandom_range(0, 199) != 0);
      clear_start = ($urandom_range(0, 399) == 0);
      clear_char  = 8'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
